gate_exerciser: RTL and testbench
=================================

Name: gate_exerciser

Overview:
- Self-checking stimulus/response stage for the two-input basic gates (nand, and, nor, ...).
- Drives the gate's two inputs through all four patterns, waits a settle interval, then samples the gate output.
- Compares each sample against a parameterised truth table and reports per-pattern failures, an error count and pass/done status.
- Sits directly upstream (feeds x, y) and downstream (consumes z) of a single gate instance.

Parameters:
- SETTLE_CYC, 1, cycles the pattern is held before the sample cycle; legal range 1..15.
- EXP_TABLE, 4'b0111, expected z per pattern; bit index = {x,y}. Default is the NAND truth table; 4'b0001 = NOR, 4'b1000 = AND.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a sweep; sampled only in IDLE.
- gate_x  output  1  drives gate input x (registered).
- gate_y  output  1  drives gate input y (registered).
- gate_z  input  1  gate output under test.
- busy  output  1  high from the cycle after start is accepted until the sweep completes.
- done  output  1  one-cycle pulse at end of sweep.
- pass  output  1  1 when the last completed sweep had zero mismatches; holds until next start.
- fail_vec  output  4  bit i set if pattern i mismatched; holds until next start.
- err_count  output  3  number of mismatching patterns, 0..4; holds until next start.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: gate_x=0, gate_y=0, busy=0, done=0, pass=0, fail_vec=0, err_count=0, state=IDLE, idx=0, settle counter=0.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - gate_x/gate_y = 0, busy=0.
  - On a clk edge with start=1: idx<=0, fail_vec<=0, err_count<=0, pass<=0, settle counter<=0, gate_x<=0, gate_y<=0, busy<=1, next state SETTLE.
- SETTLE:
  - gate_x=idx[1], gate_y=idx[0] held stable.
  - Counter increments each cycle; after SETTLE_CYC cycles in SETTLE, go to SAMPLE.
- SAMPLE:
  - Lasts exactly one cycle.
  - At its closing edge, gate_z is compared with EXP_TABLE[idx]. A mismatch sets fail_vec[idx] and increments err_count.
  - An unknown/high-Z gate_z counts as a mismatch: use case-inequality in the compare.
  - If idx==3, go to DONE. Otherwise idx<=idx+1, gate_x/gate_y update to the new idx at the same edge, counter<=0, go to SETTLE.
- DONE:
  - One cycle: done=1, busy=0, pass=(err_count==0) using the final updated count, then go to IDLE.
  - gate_x/gate_y return to 0 on entering IDLE.
- Latency:
  - Counting the start-accept edge as edge 0, the final sample occurs at edge 4*(SETTLE_CYC+1).
  - done is high for the cycle following that edge.
  - With SETTLE_CYC=1, done is visible after edge 8.
- Boundary rules:
  - start while busy or in DONE is ignored; no restart and no clearing of results.
  - start held continuously re-triggers a new sweep on the first IDLE cycle after DONE.
  - Reset mid-sweep clears everything to reset values immediately, without waiting for a clock; the partial results are discarded.
  - err_count never exceeds 4; no wrap logic is needed, but the width is fixed at 3.
  - gate_x/gate_y never change during SETTLE or SAMPLE of a pattern. Transitions happen only on the SAMPLE→SETTLE edge, giving the gate the full settle window.
  - Results (pass, fail_vec, err_count) are cleared only by reset or by an accepted start.

Test Plan:
- Real NAND gate attached, defaults, start pulse at edge 0 → gate_x/gate_y sequence 00,01,10,11 (2 cycles each); done pulse after edge 8; pass=1, fail_vec=4'b0000, err_count=0.
- gate_z tied to 1 → fail_vec=4'b1000, err_count=1, pass=0.
- AND gate attached with EXP_TABLE=4'b0111 → fail_vec=4'b1111, err_count=4, pass=0. Then start again with a NAND gate → results cleared at accept; pass=1 at done.
- SETTLE_CYC=3, EXP_TABLE=4'b0001, NOR gate attached → each pattern held 4 cycles; done after edge 16; pass=1.
- start re-pulsed at edges 3 and 5 of a sweep → ignored: a single done, results unchanged by the extra pulses. gate_z forced to X on pattern 2 → fail_vec[2]=1.
- rst asserted asynchronously between clock edges during pattern 2 → all outputs 0 before the next edge. After release, start → full clean sweep with correct results.

Source files
------------

// File: rtl/gate_exerciser.sv
// gate_exerciser: sweeps a two-input gate through patterns 00, 01, 10 and 11.
// Each pattern is held for SETTLE_CYC cycles and then sampled for one cycle.
// Each sample is compared against EXP_TABLE, indexed by {x,y}.
// pass, fail_vec and err_count keep the last sweep's results until the next accepted start.
module gate_exerciser #(
  parameter int         SETTLE_CYC = 1,
  parameter logic [3:0] EXP_TABLE  = 4'b0111
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       gate_x,
  output logic       gate_y,
  input  logic       gate_z,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_vec,
  output logic [2:0] err_count
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

  state_t     state;
  logic [1:0] idx;
  logic [1:0] idx_next;
  logic [3:0] settle_cnt;
  logic       mismatch;
  logic [2:0] err_next;

  // Decide whether the current sample mismatches.
  // Case-inequality makes an X or Z on gate_z count as a mismatch.
  // The incremented count is computed here so that pass can use the final value.
  always_comb begin
    mismatch = (gate_z !== EXP_TABLE[idx]);
    err_next = err_count + {2'b00, mismatch};
    idx_next = idx + 2'd1;
  end

  // Sweep controller.
  // Outputs are registered, and gate_x/gate_y change only on the SAMPLE->SETTLE edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= 2'd0;
      settle_cnt <= 4'd0;
      gate_x     <= 1'b0;
      gate_y     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_vec   <= 4'd0;
      err_count  <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          gate_x <= 1'b0;
          gate_y <= 1'b0;
          busy   <= 1'b0;
          done   <= 1'b0;
          if (start) begin
            idx        <= 2'd0;
            settle_cnt <= 4'd0;
            fail_vec   <= 4'd0;
            err_count  <= 3'd0;
            pass       <= 1'b0;
            busy       <= 1'b1;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          settle_cnt <= settle_cnt + 4'd1;
          if (settle_cnt == SETTLE_LAST) begin
            state <= SAMPLE;
          end
        end
        SAMPLE: begin
          if (mismatch) begin
            fail_vec[idx] <= 1'b1;
          end
          err_count <= err_next;
          if (idx == 2'd3) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            pass  <= (err_next == 3'd0);
            state <= DONE;
          end else begin
            idx        <= idx_next;
            gate_x     <= idx_next[1];
            gate_y     <= idx_next[0];
            settle_cnt <= 4'd0;
            state      <= SETTLE;
          end
        end
        DONE: begin
          done   <= 1'b0;
          gate_x <= 1'b0;
          gate_y <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_exerciser.sv
// Testbench for gate_exerciser.
// dut_a uses the defaults (NAND table, SETTLE_CYC=1) and is driven by a selectable gate model.
// dut_b uses SETTLE_CYC=3 with the NOR table and has a real NOR gate attached.
module tb_gate_exerciser;

  localparam int M_NAND  = 0;
  localparam int M_AND   = 1;
  localparam int M_TIE1  = 2;
  localparam int M_XPAT2 = 3;

  typedef struct {
    logic       pass;
    logic [3:0] fail_vec;
    logic [2:0] err_count;
  } exp_t;

  typedef struct {
    bit   sel;
    int   mode;
    bit   repulse;
    exp_t e;
  } vec_t;

  logic clock;
  logic reset;
  logic start_cmd;
  bit   sel;
  int   gate_mode;

  logic start_a, gx_a, gy_a, gz_a, busy_a, done_a, pass_a;
  logic [3:0] fv_a;
  logic [2:0] ec_a;
  logic start_b, gx_b, gy_b, gz_b, busy_b, done_b, pass_b;
  logic [3:0] fv_b;
  logic [2:0] ec_b;

  logic cx, cy, cbusy, cdone, cpass;
  logic [3:0] cfv;
  logic [2:0] cec;

  int checks = 0;
  int passed = 0;
  exp_t sb[$];
  vec_t vecs[5];

  gate_exerciser dut_a (
    .clk(clock), .rst(reset), .start(start_a), .gate_x(gx_a), .gate_y(gy_a),
    .gate_z(gz_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .fail_vec(fv_a), .err_count(ec_a)
  );

  gate_exerciser #(.SETTLE_CYC(3), .EXP_TABLE(4'b0001)) dut_b (
    .clk(clock), .rst(reset), .start(start_b), .gate_x(gx_b), .gate_y(gy_b),
    .gate_z(gz_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .fail_vec(fv_b), .err_count(ec_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign start_a = start_cmd & ~sel;
  assign start_b = start_cmd & sel;
  assign gz_b    = ~(gx_b | gy_b);

  assign cx    = sel ? gx_b   : gx_a;
  assign cy    = sel ? gy_b   : gy_a;
  assign cbusy = sel ? busy_b : busy_a;
  assign cdone = sel ? done_b : done_a;
  assign cpass = sel ? pass_b : pass_a;
  assign cfv   = sel ? fv_b   : fv_a;
  assign cec   = sel ? ec_b   : ec_a;

  // Gate model attached to dut_a.
  always_comb begin
    case (gate_mode)
      M_AND:   gz_a = gx_a & gy_a;
      M_TIE1:  gz_a = 1'b1;
      M_XPAT2: gz_a = (gx_a & ~gy_a) ? 1'bx : ~(gx_a & gy_a);
      default: gz_a = ~(gx_a & gy_a);
    endcase
  end

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) $display("[TB] FAIL %s: got %b, expected %b at %0t", name, act, req, $time);
    else passed++;
  endtask

  task automatic checkResults(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      $display("[TB] FAIL %s: scoreboard empty, got done without queued expectation", name);
    end else begin
      e = sb.pop_front();
      checkOutput({name, "_pass"}, {7'd0, cpass}, {7'd0, e.pass});
      checkOutput({name, "_fail_vec"}, {4'd0, cfv}, {4'd0, e.fail_vec});
      checkOutput({name, "_err_count"}, {5'd0, cec}, {5'd0, e.err_count});
    end
  endtask

  // Runs one full sweep and checks the gate drive on every cycle, plus done timing and results.
  // Optionally re-pulses start so that it is sampled at edges 3 and 5.
  task automatic applyStimulus(input vec_t v);
    int per;
    int total;
    int p;
    sel = v.sel;
    gate_mode = v.mode;
    per = v.sel ? 4 : 2;
    total = 4 * per;
    @(negedge clock);
    start_cmd = 1'b1;
    sb.push_back(v.e);
    @(posedge clock);
    #1 start_cmd = 1'b0;
    for (int k = 0; k < total; k++) begin
      @(negedge clock);
      p = k / per;
      checkOutput("gate_x", {7'd0, cx}, {7'd0, p[1]});
      checkOutput("gate_y", {7'd0, cy}, {7'd0, p[0]});
      checkOutput("busy", {7'd0, cbusy}, 8'd1);
      checkOutput("done_early", {7'd0, cdone}, 8'd0);
      start_cmd = (v.repulse && (k == 2 || k == 4)) ? 1'b1 : 1'b0;
      @(posedge clock);
    end
    @(negedge clock);
    start_cmd = 1'b0;
    checkOutput("done_pulse", {7'd0, cdone}, 8'd1);
    checkOutput("busy_at_done", {7'd0, cbusy}, 8'd0);
    checkResults("sweep");
    @(negedge clock);
    checkOutput("done_cleared", {7'd0, cdone}, 8'd0);
    checkOutput("idle_x", {7'd0, cx}, 8'd0);
    checkOutput("idle_y", {7'd0, cy}, 8'd0);
    checkOutput("hold_fail_vec", {4'd0, cfv}, {4'd0, v.e.fail_vec});
    checkOutput("hold_pass", {7'd0, cpass}, {7'd0, v.e.pass});
  endtask

  initial begin
    vecs[0] = '{sel: 1'b0, mode: M_NAND,  repulse: 1'b0, e: '{1'b1, 4'b0000, 3'd0}};
    vecs[1] = '{sel: 1'b0, mode: M_TIE1,  repulse: 1'b0, e: '{1'b0, 4'b1000, 3'd1}};
    vecs[2] = '{sel: 1'b0, mode: M_AND,   repulse: 1'b0, e: '{1'b0, 4'b1111, 3'd4}};
    vecs[3] = '{sel: 1'b0, mode: M_NAND,  repulse: 1'b0, e: '{1'b1, 4'b0000, 3'd0}};
    vecs[4] = '{sel: 1'b1, mode: M_NAND,  repulse: 1'b0, e: '{1'b1, 4'b0000, 3'd0}};

    start_cmd = 1'b0;
    sel = 1'b0;
    gate_mode = M_NAND;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      checkOutput("rst_x", {7'd0, cx}, 8'd0);
      checkOutput("rst_busy", {7'd0, cbusy}, 8'd0);
      checkOutput("rst_done", {7'd0, cdone}, 8'd0);
      checkOutput("rst_pass", {7'd0, cpass}, 8'd0);
      checkOutput("rst_fail_vec", {4'd0, cfv}, 8'd0);
      checkOutput("rst_err_count", {5'd0, cec}, 8'd0);
    end
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i]);
    end

    // Extra start pulses mid-sweep must be ignored; X on pattern 2 counts as a mismatch.
    applyStimulus('{sel: 1'b0, mode: M_XPAT2, repulse: 1'b1, e: '{1'b0, 4'b0100, 3'd1}});
    repeat (3) @(negedge clock);
    checkOutput("no_restart_busy", {7'd0, busy_a}, 8'd0);

    // A held start re-triggers on the first IDLE cycle after DONE.
    sel = 1'b0;
    gate_mode = M_NAND;
    @(negedge clock);
    start_cmd = 1'b1;
    sb.push_back('{1'b1, 4'b0000, 3'd0});
    sb.push_back('{1'b1, 4'b0000, 3'd0});
    @(posedge clock);
    repeat (8) @(posedge clock);
    @(negedge clock);
    checkOutput("held_done1", {7'd0, done_a}, 8'd1);
    checkResults("held1");
    repeat (2) @(posedge clock);
    @(negedge clock);
    checkOutput("held_rebusy", {7'd0, busy_a}, 8'd1);
    start_cmd = 1'b0;
    repeat (8) @(posedge clock);
    @(negedge clock);
    checkOutput("held_done2", {7'd0, done_a}, 8'd1);
    checkResults("held2");
    repeat (2) @(negedge clock);

    // An asynchronous reset during pattern 2 clears everything before the next edge.
    sel = 1'b0;
    gate_mode = M_AND;
    @(negedge clock);
    start_cmd = 1'b1;
    @(posedge clock);
    #1 start_cmd = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    checkOutput("pre_rst_fail_vec", {4'd0, fv_a}, 8'b0000_0011);
    checkOutput("pre_rst_x", {7'd0, gx_a}, 8'd1);
    #1 reset = 1'b1;
    #1;
    checkOutput("async_rst_x", {7'd0, gx_a}, 8'd0);
    checkOutput("async_rst_busy", {7'd0, busy_a}, 8'd0);
    checkOutput("async_rst_fail_vec", {4'd0, fv_a}, 8'd0);
    checkOutput("async_rst_err_count", {5'd0, ec_a}, 8'd0);
    checkOutput("async_rst_pass", {7'd0, pass_a}, 8'd0);
    @(negedge clock);
    reset = 1'b0;
    applyStimulus('{sel: 1'b0, mode: M_NAND, repulse: 1'b0, e: '{1'b1, 4'b0000, 3'd0}});

    checks++;
    if (sb.size() != 0) $display("[TB] FAIL scoreboard_leftover: got %0d entries, expected 0", sb.size());
    else passed++;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not complete, expected finish before 200000");
    $fatal(1);
  end

endmodule
